// File: rtl/key_loader.sv
// key_loader
//   Buffers 64-bit key words written by a host in a DEPTH-entry circular FIFO
//   and, once a full burst is buffered while the controller waits for a
//   message, streams the burst oldest-first to the controller, then holds the
//   start request until the controller reports a result.
//
// Ports
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   host_wr     host write strobe, one word per high cycle
//   host_data   host write word
//   host_full   FIFO holds DEPTH words (combinational from occupancy)
//   overflow    sticky: a host write was dropped because the FIFO was full
//   mode        controller phase; 3'b010 = waiting for a message
//   data_ready  controller result-valid flag (only looked at in WAITDONE)
//   data_out    head word while streaming, 0 otherwise
//   start       controller start request (registered)
//   busy        high whenever the loader is not idle (registered)
module key_loader #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        host_wr,
  input  logic [63:0] host_data,
  output logic        host_full,
  output logic        overflow,
  input  logic [2:0]  mode,
  input  logic        data_ready,
  output logic [63:0] data_out,
  output logic        start,
  output logic        busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0]       MODE_WAIT_MSG = 3'b010;
  localparam logic [CNT_W-1:0] FULL_CNT      = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_IDX      = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAITDONE,
    S_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_beat;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_start;
  logic             r_busy;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_last_beat;

  // Fullness is judged on the occupancy before this cycle's pop, so a write
  // arriving on the first streaming beat of a full FIFO is still dropped.
  assign w_full      = (r_count == FULL_CNT);
  assign w_push      = host_wr && !w_full;
  assign w_pop       = (r_state == S_STREAM);
  assign w_last_beat = (r_beat == LAST_IDX);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_full && (mode == MODE_WAIT_MSG)) w_state_nxt = S_STREAM;
      S_STREAM:   if (w_last_beat) w_state_nxt = S_WAITDONE;
      S_WAITDONE: if (data_ready) w_state_nxt = S_RELEASE;
      S_RELEASE:  w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Storage carries no reset: contents are only visible through data_out,
  // which is forced to 0 outside STREAM, and STREAM needs a full reload.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= host_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_beat     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (host_wr && w_full) r_overflow <= 1'b1;

      if (r_state == S_STREAM) r_beat <= w_last_beat ? '0 : r_beat + PTR_W'(1);
      else                     r_beat <= '0;

      // Decoded from the next state so the registered flags line up with
      // the state they describe rather than lagging it by a cycle.
      r_start <= (w_state_nxt == S_STREAM) || (w_state_nxt == S_WAITDONE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign host_full = w_full;
  assign overflow  = r_overflow;
  assign start     = r_start;
  assign busy      = r_busy;
  assign data_out  = (r_state == S_STREAM) ? r_mem[r_rd_ptr] : 64'd0;

endmodule

// File: tb/tb_key_loader.sv
// Testbench for key_loader: constant vector tables for the basic burst and
// overflow cases, scripted sequences for push-during-burst and mid-burst
// reset, and a randomized run checked against a queue-based reference model.
module tb_key_loader;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        host_wr;
  logic [63:0] host_data;
  logic        host_full;
  logic        overflow;
  logic [2:0]  mode;
  logic        data_ready;
  logic [63:0] data_out;
  logic        start;
  logic        busy;

  always #5 clk = ~clk;

  key_loader #(.DEPTH(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .host_wr    (host_wr),
    .host_data  (host_data),
    .host_full  (host_full),
    .overflow   (overflow),
    .mode       (mode),
    .data_ready (data_ready),
    .data_out   (data_out),
    .start      (start),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of buffered words plus the loader phase
  // (0 idle, 1 streaming with m_left words still to send, 2 waiting, 3 release).
  logic [63:0] m_q[$];
  int          m_ph;
  int          m_left;
  int          m_bursts;
  bit          m_ovf;

  typedef struct {
    bit          rst;
    bit          wr;
    logic [63:0] d;
    logic [2:0]  md;
    bit          dr;
    bit          st;
    bit          bz;
    bit          fu;
    bit          ov;
    logic [63:0] dout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(bit rst, bit wr, logic [63:0] d, logic [2:0] md, bit dr,
                              bit st, bit bz, bit fu, bit ov, logic [63:0] dout);
    vec_t v;
    v.rst = rst; v.wr = wr; v.d = d; v.md = md; v.dr = dr;
    v.st = st; v.bz = bz; v.fu = fu; v.ov = ov; v.dout = dout;
    tbl.push_back(v);
  endfunction

  task automatic model_step(input bit wr, input logic [63:0] d, input logic [2:0] md, input bit dr);
    int sz;
    bit pop;
    bit push_ok;
    sz      = m_q.size();
    pop     = (m_ph == 1);
    push_ok = wr && (sz < 8);
    if (wr && !push_ok) m_ovf = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push_ok) m_q.push_back(d);
    case (m_ph)
      0: if (sz == 8 && md == 3'b010) begin m_ph = 1; m_left = 8; m_bursts++; end
      1: begin m_left--; if (m_left == 0) m_ph = 2; end
      2: if (dr) m_ph = 3;
      default: m_ph = 0;
    endcase
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_start"}, start,     (m_ph == 1 || m_ph == 2));
    chk({tag, "_busy"},  busy,      (m_ph != 0));
    chk({tag, "_full"},  host_full, (m_q.size() == 8));
    chk({tag, "_ovf"},   overflow,  m_ovf);
    chk({tag, "_dout"},  data_out,  (m_ph == 1) ? m_q[0] : 64'd0);
  endtask

  task automatic cyc(input bit wr, input logic [63:0] d, input logic [2:0] md, input bit dr);
    host_wr    = wr;
    host_data  = d;
    mode       = md;
    data_ready = dr;
    @(posedge clk);
    model_step(wr, d, md, dr);
    #1;
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic do_reset(input string tag);
    n_rst = 1'b0;
    m_q.delete();
    m_ph = 0; m_left = 0; m_ovf = 1'b0;
    #1;
    chk({tag, "_rst_start"}, start,     1'b0);
    chk({tag, "_rst_busy"},  busy,      1'b0);
    chk({tag, "_rst_full"},  host_full, 1'b0);
    chk({tag, "_rst_ovf"},   overflow,  1'b0);
    chk({tag, "_rst_dout"},  data_out,  64'd0);
    host_wr = 1'b0; data_ready = 1'b0; mode = 3'b000; host_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pend[$];
    bit          wr;
    logic [63:0] d;

    n_rst = 1'b0; host_wr = 1'b0; host_data = '0; mode = 3'b000; data_ready = 1'b0;
    m_bursts = 0;

    // Burst of 1..8, long wait, release, back to idle; data_ready is driven
    // high while streaming and must be ignored there.
    for (int i = 0; i < 8; i++) add(i == 0, 1, 64'(i + 1), 3'b010, 0, 0, 0, i == 7, 0, 64'd0);
    for (int k = 0; k < 8; k++) add(0, 0, 64'd0, 3'b010, 1, 1, 1, k == 0, 0, 64'(k + 1));
    for (int w = 0; w < 51; w++) add(0, 0, 64'd0, 3'b010, 0, 1, 1, 0, 0, 64'd0);
    add(0, 0, 64'd0, 3'b010, 1, 0, 1, 0, 0, 64'd0);
    add(0, 0, 64'd0, 3'b010, 0, 0, 0, 0, 0, 64'd0);
    add(0, 0, 64'd0, 3'b010, 0, 0, 0, 0, 0, 64'd0);
    // Nine writes while the controller is not waiting: ninth is dropped.
    for (int i = 0; i < 9; i++) add(i == 0, 1, 64'(i + 1), 3'b000, 0, 0, 0, i >= 7, i == 8, 64'd0);
    for (int k = 0; k < 8; k++) add(0, 0, 64'd0, 3'b010, 0, 1, 1, k == 0, 1, 64'(k + 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset($sformatf("v%0d", i));
      cyc(tbl[i].wr, tbl[i].d, tbl[i].md, tbl[i].dr);
      chk($sformatf("v%0d_start", i), start,     tbl[i].st);
      chk($sformatf("v%0d_busy", i),  busy,      tbl[i].bz);
      chk($sformatf("v%0d_full", i),  host_full, tbl[i].fu);
      chk($sformatf("v%0d_ovf", i),   overflow,  tbl[i].ov);
      chk($sformatf("v%0d_dout", i),  data_out,  tbl[i].dout);
    end

    // Push 11..18 while a burst of 1..8 streams; second burst only after
    // release and once mode says the controller is waiting again.
    do_reset("pd");
    for (int i = 0; i < 8; i++) begin cyc(1, 64'(i + 1), 3'b010, 0); chk_model("pd_ld"); end
    cyc(0, 64'd0, 3'b010, 0);
    chk_model("pd_go");
    for (int i = 0; i < 8; i++) pend.push_back(64'h11 + 64'(i));
    for (int i = 0; i < 40; i++) begin
      wr = (pend.size() > 0) && (m_q.size() < 8);
      d  = wr ? pend[0] : 64'd0;
      cyc(wr, d, 3'b000, i == 25);
      if (wr) void'(pend.pop_front());
      chk_model("pd_run");
    end
    chk("pd_all_pushed", 64'(pend.size()), 64'd0);
    chk("pd_no_ovf", overflow, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 64'd0, 3'b010, 0);
      chk_model("pd_b2");
      if (i < 8) chk($sformatf("pd_b2_word%0d", i), data_out, 64'h11 + 64'(i));
    end

    // Reset at beat 3 of a burst, then a fresh load streams cleanly.
    do_reset("mr");
    for (int i = 0; i < 9; i++) begin cyc(1, 64'hA1 + 64'(i), 3'b010, 0); chk_model("mr_ld"); end
    for (int i = 0; i < 3; i++) begin cyc(0, 64'd0, 3'b000, 0); chk_model("mr_st"); end
    chk("mr_beat3_word", data_out, 64'hA4);
    chk("mr_beat3_ovf", overflow, 1'b1);
    do_reset("mr_mid");
    for (int i = 0; i < 4; i++) begin cyc(0, 64'd0, 3'b010, 0); chk_model("mr_quiet"); end
    for (int i = 0; i < 8; i++) begin cyc(1, 64'hC1 + 64'(i), 3'b000, 0); chk_model("mr_rl"); end
    for (int i = 0; i < 12; i++) begin cyc(0, 64'd0, 3'b010, 0); chk_model("mr_b"); end

    // Randomized traffic: writes at arbitrary times across many bursts so
    // the pointers wrap at non-aligned offsets.
    do_reset("rnd");
    m_bursts = 0;
    for (int i = 0; i < 900; i++) begin
      cyc($urandom_range(0, 9) < 6, {$urandom, $urandom},
          ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7)),
          $urandom_range(0, 3) == 0);
      chk_model($sformatf("rnd%0d", i));
    end
    chk("rnd_bursts_ge3", 64'(m_bursts >= 3), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of 64-bit words per burst and the number of FIFO entries.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port host_wr, input, 1 bit: host write strobe, one word per high cycle.
REQ-005 SHALL have port host_data, input, 64 bits: host write word.
REQ-006 SHALL have port host_full, output, 1 bit: FIFO holds DEPTH words.
REQ-007 SHALL have port overflow, output, 1 bit: sticky flag, a write was dropped.
REQ-008 SHALL have port mode, input, 3 bits: controller phase; 3'b010 means waiting for a message.
REQ-009 SHALL have port data_ready, input, 1 bit: controller result-valid flag.
REQ-010 SHALL have port data_out, output, 64 bits: word stream to the controller's data_in.
REQ-011 SHALL have port start, output, 1 bit: controller start request.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL store words in a DEPTH-entry circular FIFO with 3-bit read/write pointers that wrap from 7 to 0 and a 4-bit occupancy count (0..8).
REQ-014 SHALL accept a write when host_wr=1 and count<8 (count sampled before this cycle's pop); the word is stored at wr_ptr, and wr_ptr increments.
REQ-015 SHALL ignore a write when host_wr=1 and count==8, leave the FIFO unchanged, and set overflow=1 until reset.
REQ-016 SHALL drive host_full=(count==8) combinationally.
REQ-017 SHALL allow a push and a pop in the same cycle; count is then unchanged and both pointers advance.
REQ-018 SHALL implement FSM states IDLE, STREAM, WAITDONE and RELEASE.
REQ-019 SHALL, in IDLE, drive start=0 and data_out=0, and go to STREAM when count==8 and mode==3'b010 in the same cycle.
REQ-020 SHALL, in STREAM, drive start=1 and data_out=FIFO[rd_ptr], pop one word per cycle, and run a 3-bit beat counter from 0 to 7.
REQ-021 SHALL go from STREAM to WAITDONE after beat 7, so that exactly 8 beats are streamed in oldest-first order.
REQ-022 SHALL present the first word on the first STREAM cycle (latency 1 clock from the IDLE qualifying condition).
REQ-023 SHALL, in WAITDONE, hold start=1 and data_out=0, and go to RELEASE when data_ready=1.
REQ-024 SHALL, in RELEASE, drive start=0 and data_out=0 for exactly 1 cycle, then go to IDLE.
REQ-025 SHALL start a new burst only after returning to IDLE with count==8 and mode==3'b010, even when words were pushed during STREAM, WAITDONE or RELEASE.
REQ-026 SHALL register start and busy from the state; data_out is the combinational head word during STREAM and 0 otherwise.
REQ-027 SHALL ignore data_ready outside WAITDONE.
REQ-028 SHALL ignore mode outside IDLE.

Reset
REQ-029 SHALL, when n_rst=0, immediately clear state to IDLE, pointers, count, beat counter and overflow to 0, and force start=0, busy=0, data_out=0 and host_full=0.
REQ-030 SHALL discard all FIFO contents on reset asserted mid-burst; no partial stream resumes after release.
REQ-031 SHALL leave FIFO storage values undefined-but-unused after reset; they are never observable, since data_out is 0 outside STREAM.

Verification
REQ-032 SHALL be covered by this scenario: write 8 words 64'h1..64'h8 with mode=3'b010 -> start rises 1 clock after the 8th write, data_out shows 1..8 on 8 consecutive cycles, and host_full falls during streaming.
REQ-033 SHALL be covered by this scenario: 9 consecutive writes with mode=3'b000 -> host_full=1 after the 8th write, overflow=1 after the 9th, and the FIFO holds words 1..8.
REQ-034 SHALL be covered by this scenario: after the stream completes, hold data_ready=0 for 50 cycles then pulse it for 1 cycle -> start stays 1 through the wait, is 0 for 1 cycle in RELEASE, and busy=0 the next cycle.
REQ-035 SHALL be covered by this scenario: push 8 new words (64'h11..64'h18) while a burst streams -> no word loss, and a second burst streams 11..18 only after RELEASE and mode==3'b010.
REQ-036 SHALL be covered by this scenario: assert n_rst=0 at STREAM beat 3 -> start, data_out, count and overflow are all 0 asynchronously, and a fresh 8-word load after release streams correctly.
REQ-037 SHALL be covered by this scenario: pointer wrap, meaning 3 bursts with writes interleaved at non-aligned times -> output order always matches write order.
